// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, configurable frame format and a first-word-fall-through RX FIFO.
// Sticky framing/parity/overrun flags; eol marks CR/LF bytes as they enter the FIFO.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          RX,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          eol,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  input  logic                          clr_err,
  output logic                          busy
);

  localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int S_W   = $clog2(OVERSAMPLE);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [S_W-1:0] S_HALF = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_FULL = S_W'(OVERSAMPLE - 1);

  // IDLE: wait start edge | START: verify start at half bit | DATA | PAR | STOP | BRK: wait line high
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

  state_t               state_q, state_d;
  logic                 rx_s1, rx_s2, rx_d;
  logic [DIV_W-1:0]     div_q;
  logic                 tick;
  logic [S_W-1:0]       s_q, s_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 bad_q, bad_d;
  logic                 wr_q, wr_set, fe_set, pe_set, par_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
      div_q <= '0;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
      div_q <= tick ? '0 : div_q + 1'b1;
    end
  end

  assign tick    = (div_q == DIV_W'(DIV - 1));
  assign par_bad = (^{sh_q, rx_s2}) != (PARITY == 1);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    bad_d   = bad_q;
    wr_set  = 1'b0;
    fe_set  = 1'b0;
    pe_set  = 1'b0;
    case (state_q)
      IDLE: if (!rx_s2 && rx_d) begin
        state_d = START;
        s_d     = '0;
        bad_d   = 1'b0;
      end
      START: if (tick) begin
        if (s_q == S_HALF) begin
          state_d = rx_s2 ? IDLE : DATA;
          s_d     = '0;
          bit_d   = '0;
        end else s_d = s_q + 1'b1;
      end
      DATA: if (tick) begin
        if (s_q == S_FULL) begin
          s_d  = '0;
          sh_d = {rx_s2, sh_q[DATA_BITS-1:1]};
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end else bit_d = bit_q + 1'b1;
        end else s_d = s_q + 1'b1;
      end
      PAR: if (tick) begin
        if (s_q == S_FULL) begin
          s_d     = '0;
          state_d = STOP;
          if (par_bad) begin
            pe_set = 1'b1;
            bad_d  = 1'b1;
          end
        end else s_d = s_q + 1'b1;
      end
      STOP: if (tick) begin
        if (s_q == S_FULL) begin
          s_d = '0;
          if (!rx_s2) begin
            fe_set  = 1'b1;
            bad_d   = 1'b1;
            state_d = BRK;
          end else if (bit_q == 4'(STOP_BITS - 1)) begin
            wr_set  = !bad_q;
            state_d = IDLE;
          end else bit_d = bit_q + 1'b1;
        end else s_d = s_q + 1'b1;
      end
      BRK: if (rx_s2) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      bad_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      bad_q   <= bad_d;
      wr_q    <= wr_set;
    end
  end

  assign busy = (state_q != IDLE);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wptr_q, rptr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 full, do_pop, do_push, eol_hit;

  assign full     = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign rd_valid = (cnt_q != '0);
  assign do_pop   = rd_en && rd_valid;
  // A full FIFO still accepts the byte when a pop frees the slot in the same cycle.
  assign do_push  = wr_q && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= sh_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      frame_err  <= fe_set ? 1'b1 : (clr_err ? 1'b0 : frame_err);
      parity_err <= pe_set ? 1'b1 : (clr_err ? 1'b0 : parity_err);
      overrun    <= (wr_q && full && !rd_en) ? 1'b1 : (clr_err ? 1'b0 : overrun);
    end
  end

  assign rd_data    = rd_valid ? mem[rptr_q] : '0;
  assign fifo_count = cnt_q;

  generate
    if (DATA_BITS >= 7) begin : g_eol
      assign eol_hit = (sh_q == DATA_BITS'(8'h0A)) || (sh_q == DATA_BITS'(8'h0D));
    end else begin : g_no_eol
      assign eol_hit = 1'b0;
    end
  endgenerate

  assign eol = do_push && eol_hit;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed frame table, multi-cycle corner sequences, and randomized
// byte streams scored against a queue-based model of the receive FIFO.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int BIT = 64;   // 4 clk per tick x 16 ticks

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, rx = 1'b1, rx_p = 1'b1, rd_en = 1'b0, rd_en_p = 1'b0, clr_err = 1'b0;
  logic [7:0] rd_data, rd_data_p;
  logic [4:0] cnt, cnt_p;
  logic       rd_valid, rd_valid_p, eol, eol_p, fe, fe_p, pe, pe_p, ovr, ovr_p, busy, busy_p;

  int checks = 0, errors = 0;
  int eol_cnt = 0, fe_rises = 0;
  logic fe_q = 1'b0;

  uart_rx_fifo #(.CLK_HZ(100_000_000), .BAUD(1_562_500), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .RX(rx), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_count(cnt), .eol(eol), .frame_err(fe), .parity_err(pe), .overrun(ovr),
    .clr_err(clr_err), .busy(busy));

  uart_rx_fifo #(.CLK_HZ(100_000_000), .BAUD(1_562_500), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_p (
    .clk(clk), .rst_n(rst_n), .RX(rx_p), .rd_en(rd_en_p), .rd_data(rd_data_p), .rd_valid(rd_valid_p),
    .fifo_count(cnt_p), .eol(eol_p), .frame_err(fe_p), .parity_err(pe_p), .overrun(ovr_p),
    .clr_err(clr_err), .busy(busy_p));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (eol) eol_cnt <= eol_cnt + 1;
    fe_q <= fe;
    if (fe && !fe_q) fe_rises <= fe_rises + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic line(input bit on_p, input logic v);
    if (on_p) rx_p = v; else rx = v;
  endtask

  task automatic send(input bit on_p, input logic [8:0] d, input int nbits, input logic stopv);
    line(on_p, 1'b0);
    clks(BIT);
    for (int i = 0; i < nbits; i++) begin
      line(on_p, d[i]);
      clks(BIT);
    end
    line(on_p, stopv);
    clks(BIT);
  endtask

  task automatic idle(input int bits);
    rx = 1'b1;
    clks(bits * BIT);
  endtask

  task automatic pop;
    rd_en = 1'b1;
    clks(1);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr;
    clr_err = 1'b1;
    clks(1);
    clr_err = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stopv;
    int         gap;
    logic [4:0] exp_count;
    logic       exp_fe;
    int         exp_eol;
  } vec_t;

  vec_t       tbl[5];
  logic [7:0] model_q[$];
  logic [7:0] exp_b, b;
  int         base, w, n;
  logic       bad, exp_fe, exp_ovr;

  initial begin
    tbl[0] = '{8'h55, 1'b1, 0, 5'd1, 1'b0, 0};
    tbl[1] = '{8'hA3, 1'b1, 0, 5'd2, 1'b0, 0};
    tbl[2] = '{8'h0D, 1'b1, 1, 5'd3, 1'b0, 1};
    tbl[3] = '{8'h41, 1'b0, 1, 5'd3, 1'b1, 1};
    tbl[4] = '{8'h0A, 1'b1, 1, 5'd4, 1'b1, 2};

    clks(3);
    check("reset_count", cnt, 0);
    check("reset_valid", rd_valid, 0);
    check("reset_flags", {fe, pe, ovr, busy, eol}, 0);
    check("reset_rd_data", rd_data, 0);
    rst_n = 1'b1;
    clks(BIT);

    // Directed frame table: back-to-back 0x55/0xA3/0x0D, a bad stop bit, then LF.
    base = eol_cnt;
    for (int i = 0; i < 5; i++) begin
      send(1'b0, {1'b0, tbl[i].data}, 8, tbl[i].stopv);
      clks(1);
      check($sformatf("tbl%0d_count", i), cnt, tbl[i].exp_count);
      check($sformatf("tbl%0d_frame_err", i), fe, tbl[i].exp_fe);
      check($sformatf("tbl%0d_eol", i), eol_cnt - base, tbl[i].exp_eol);
      if (tbl[i].gap > 0) idle(tbl[i].gap);
    end
    check("tbl_parity_err", pe, 0);
    check("tbl_overrun", ovr, 0);
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].stopv) begin
        check($sformatf("tbl_drain%0d", i), rd_data, tbl[i].data);
        pop();
      end
    end
    check("tbl_drained", rd_valid, 0);
    pulse_clr();
    check("clr_frame_err", fe, 0);

    // Short low glitch: false start, nothing stored or flagged.
    base = eol_cnt;
    rx = 1'b0;
    clks(10);
    check("glitch_busy_high", busy, 1);
    clks(10);
    rx = 1'b1;
    clks(BIT);
    check("glitch_busy_low", busy, 0);
    check("glitch_count", cnt, 0);
    check("glitch_flags", {fe, pe, ovr}, 0);
    check("glitch_eol", eol_cnt - base, 0);

    // Bad stop bit followed by a long low line: a single frame error.
    base = fe_rises;
    send(1'b0, 9'h041, 8, 1'b0);
    clks(10 * BIT);
    check("break_frame_err", fe, 1);
    check("break_count", cnt, 0);
    check("break_fe_rises", fe_rises - base, 1);
    check("break_busy", busy, 1);
    rx = 1'b1;
    clks(5);
    check("break_exit_busy", busy, 0);
    pulse_clr();
    check("break_clr", fe, 0);

    // Even parity on 0x07: parity bit must be 1.
    send(1'b1, {1'b0, 8'h07}, 9, 1'b1);
    clks(2);
    check("par_bad_flag", pe_p, 1);
    check("par_bad_count", cnt_p, 0);
    send(1'b1, {1'b1, 8'h07}, 9, 1'b1);
    clks(2);
    check("par_good_count", cnt_p, 1);
    check("par_good_data", rd_data_p, 8'h07);
    check("par_sticky", pe_p, 1);
    pulse_clr();
    check("par_clr", pe_p, 0);

    // 17 bytes with no reads: 16 kept, one dropped.
    for (int k = 0; k < 17; k++) send(1'b0, {1'b0, 8'h20 + 8'(k)}, 8, 1'b1);
    clks(2);
    check("ovr_count", cnt, 16);
    check("ovr_flag", ovr, 1);
    check("ovr_head", rd_data, 8'h20);
    pulse_clr();
    check("ovr_clr", ovr, 0);

    // Full FIFO with rd_en in the write cycle: write and pop both happen.
    base = eol_cnt;
    w = 0;
    fork
      send(1'b0, 9'h00A, 8, 1'b1);
      begin
        while (!busy && w < 12 * BIT) begin clks(1); w++; end
        while (busy && w < 12 * BIT) begin clks(1); w++; end
        rd_en = 1'b1;
        clks(1);
        rd_en = 1'b0;
      end
    join
    check("fullrd_timing", (w < 12 * BIT), 1);
    clks(2);
    check("fullrd_count", cnt, 16);
    check("fullrd_overrun", ovr, 0);
    check("fullrd_head", rd_data, 8'h21);
    check("fullrd_eol", eol_cnt - base, 1);

    // Reset in the middle of a byte.
    fork
      send(1'b0, 9'h05A, 8, 1'b1);
      begin
        clks(3 * BIT);
        rst_n = 1'b0;
        clks(2);
        check("rst_count", cnt, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_flags", {fe, pe, ovr, busy, eol}, 0);
        check("rst_rd_data", rd_data, 0);
      end
    join
    rx = 1'b1;
    clks(4);
    rst_n = 1'b1;
    clks(2 * BIT);
    check("rst_after_count", cnt, 0);
    check("rst_after_busy", busy, 0);

    // Randomized streams against a queue model of the FIFO.
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(18, 1);
      exp_fe = 1'b0;
      exp_ovr = 1'b0;
      base = eol_cnt;
      w = 0;
      for (int k = 0; k < n; k++) begin
        b = ($urandom_range(3, 0) == 0) ? (($urandom_range(1, 0) == 1) ? 8'h0A : 8'h0D)
                                        : 8'($urandom_range(255, 0));
        bad = ($urandom_range(5, 0) == 0);
        send(1'b0, {1'b0, b}, 8, !bad);
        if (bad) exp_fe = 1'b1;
        else if (model_q.size() < 16) begin
          model_q.push_back(b);
          if (b == 8'h0A || b == 8'h0D) w++;
        end else exp_ovr = 1'b1;
        if (bad || $urandom_range(1, 0) == 1) idle(1);
      end
      idle(2);
      check($sformatf("rnd%0d_count", r), cnt, model_q.size());
      check($sformatf("rnd%0d_frame_err", r), fe, exp_fe);
      check($sformatf("rnd%0d_overrun", r), ovr, exp_ovr);
      check($sformatf("rnd%0d_eol", r), eol_cnt - base, w);
      while (model_q.size() > 0) begin
        exp_b = model_q.pop_front();
        check($sformatf("rnd%0d_data", r), rd_data, exp_b);
        pop();
        clks($urandom_range(2, 0));
      end
      check($sformatf("rnd%0d_empty", r), rd_valid, 0);
      pulse_clr();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
